// File: rtl/serialmul_pkg.sv
// Shared types and frame-length helper for the bit-serial multiplier framing stage.
package serialmul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sm_state_t;

  function automatic int unsigned frame_len(input int unsigned w, input int unsigned lat);
    return 2 * w + lat;
  endfunction

endpackage

// File: rtl/serialmul_frame_ctrl.sv
// Framing controller for the bit-serial multiply-add array: serializes B, pulses sync,
// and deserializes the LSB-first product stream into a parallel 2W-bit result.
module serialmul_frame_ctrl
  import serialmul_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [W-1:0]   a_par,
  output logic           b_ser,
  output logic           sync,
  input  logic           so_ser,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p
);

  localparam int unsigned FL = frame_len(W, LAT);
  localparam int unsigned CW = $clog2(FL);

  sm_state_t      r_state;
  sm_state_t      w_next;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_bsh;
  logic           w_first;
  logic           w_last;
  logic           w_feed;
  logic           w_capt;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CW'(FL - 1));
  assign w_feed  = (r_cnt <  CW'(W));
  assign w_capt  = (r_cnt >= CW'(LAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    sync      = (r_state == RUN) && w_first;
    b_ser     = (r_state == RUN) && w_feed && r_bsh[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_bsh <= '0;
      a_par <= '0;
      out_p <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            a_par <= in_a;
            r_bsh <= in_b;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          if (w_feed) r_bsh <= r_bsh >> 1;
          // First RUN cycle discards the previous product, even when capture starts at cnt 0.
          if (w_capt)
            out_p <= {so_ser, out_p[2*W-1:1] & {(2*W-1){~w_first}}};
          else if (w_first)
            out_p <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serialmul_frame_ctrl.sv
// Directed bench for serialmul_frame_ctrl with a behavioural bit-serial array per lane
// (lane 0: LAT=1, lane 1: LAT=3).
module tb_serialmul_frame_ctrl;
  import serialmul_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_a      [2];
  logic [7:0] in_b      [2];
  logic [7:0] a_par     [2];
  logic       b_ser     [2];
  logic       sync      [2];
  logic       so_ser    [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [15:0] out_p    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : gen_lane
    localparam int unsigned L = (g == 0) ? 1 : 3;
    int unsigned m_k;
    int unsigned k;
    logic [7:0]  m_bacc;
    logic [7:0]  bnow;
    logic [15:0] prod;
    logic        pbit;
    logic [L-1:0] dly;

    serialmul_frame_ctrl #(.W(8), .LAT(L)) dut (
      .clk(clk), .reset(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .a_par(a_par[g]),
      .b_ser(b_ser[g]), .sync(sync[g]), .so_ser(so_ser[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_p(out_p[g])
    );

    // Array model: product bit k depends only on B bits 0..k, restarted by sync.
    always_comb begin
      k    = sync[g] ? 0 : m_k;
      bnow = sync[g] ? 8'h00 : m_bacc;
      if (k < 8) bnow = bnow | (8'(b_ser[g]) << k);
      prod = 16'(a_par[g]) * 16'(bnow);
      pbit = (k < 16) ? prod[k[3:0]] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_k    <= 100;
        m_bacc <= '0;
        dly    <= '0;
      end else begin
        m_k    <= (k < 100) ? k + 1 : k;
        m_bacc <= bnow;
        dly    <= L'({dly, pbit});
      end
    end

    assign so_ser[g] = dly[L-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation; returns cycles from handshake to out_valid and sync/b_ser traces.
  task automatic do_op(input int g, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [31:0] sm, output logic [31:0] bm);
    int n;
    @(negedge clk);
    in_a[g] = a; in_b[g] = b; in_valid[g] = 1'b1;
    n = 0;
    while (!in_ready[g] && n < 60) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(in_ready[g]), 32'd1);
    @(negedge clk);
    in_valid[g] = 1'b0;
    chk("run_in_ready", 32'(in_ready[g]), 32'd0);
    chk("run_a_par", 32'(a_par[g]), 32'(a));
    sm = '0; bm = '0; n = 1;
    while (!out_valid[g] && n < 60) begin
      if (n <= 32) begin sm[n-1] = sync[g]; bm[n-1] = b_ser[g]; end
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  // Hold out_ready low for 'hold' cycles checking stability, then consume the result.
  task automatic drain(input int g, input int hold, input logic [15:0] p, input logic [7:0] a);
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", 32'(out_valid[g]), 32'd1);
      chk("hold_out_p",     32'(out_p[g]),     32'(p));
      chk("hold_in_ready",  32'(in_ready[g]),  32'd0);
      chk("hold_a_par",     32'(a_par[g]),     32'(a));
      @(negedge clk);
    end
    out_ready[g] = 1'b1;
    @(negedge clk);
    out_ready[g] = 1'b0;
    chk("drain_in_ready",  32'(in_ready[g]),  32'd1);
    chk("drain_out_valid", 32'(out_valid[g]), 32'd0);
  endtask

  initial begin
    int lat, n, t0, t1;
    logic [31:0] sm, bm;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0; out_ready[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready[0]),  32'd1);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_sync",      32'(sync[0]),      32'd0);
    chk("rst_b_ser",     32'(b_ser[0]),     32'd0);
    chk("rst_out_p",     32'(out_p[0]),     32'd0);
    chk("rst_a_par",     32'(a_par[0]),     32'd0);
    chk("rst_l3_ready",  32'(in_ready[1]),  32'd1);
    chk("rst_l3_out_p",  32'(out_p[1]),     32'd0);

    // 0xFF * 0xFF with full trace of sync and b_ser
    do_op(0, 8'hFF, 8'hFF, lat, sm, bm);
    chk("ff_sync_trace", sm, 32'h0000_0001);
    chk("ff_bser_trace", bm, 32'h0000_00FF);
    chk("ff_latency",    32'(lat), 32'd18);
    chk("ff_out_p",      32'(out_p[0]), 32'h0000_FE01);
    drain(0, 0, 16'hFE01, 8'hFF);

    // 0x0D * 0x0B with backpressure
    do_op(0, 8'h0D, 8'h0B, lat, sm, bm);
    chk("d_latency", 32'(lat), 32'd18);
    drain(0, 5, 16'h008F, 8'h0D);

    // Back-to-back: in_valid held, out_ready high
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_a[0] = 8'h03; in_b[0] = 8'h05; in_valid[0] = 1'b1;
    chk("b2b_ready0", 32'(in_ready[0]), 32'd1);
    t0 = cyc;
    @(negedge clk);
    in_a[0] = 8'h10; in_b[0] = 8'h10;
    chk("b2b_ignored", 32'(a_par[0]), 32'h03);
    n = 0;
    while (!out_valid[0] && n < 60) begin @(negedge clk); n++; end
    chk("b2b_p1", 32'(out_p[0]), 32'h0000_000F);
    n = 0;
    while (!in_ready[0] && n < 60) begin @(negedge clk); n++; end
    t1 = cyc;
    chk("b2b_spacing", 32'(t1 - t0), 32'(frame_len(8, 1) + 2));
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 60) begin @(negedge clk); n++; end
    chk("b2b_p2", 32'(out_p[0]), 32'h0000_0100);
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("b2b_idle", 32'(in_ready[0]), 32'd1);

    // Abort with reset at cnt=5
    @(negedge clk);
    in_a[0] = 8'h55; in_b[0] = 8'h33; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready",  32'(in_ready[0]),  32'd1);
    chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
    chk("abort_b_ser",     32'(b_ser[0]),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 8'h07, 8'h09, lat, sm, bm);
    chk("abort_next_lat", 32'(lat), 32'd18);
    chk("abort_next_p",   32'(out_p[0]), 32'h0000_003F);
    drain(0, 0, 16'h003F, 8'h07);

    // LAT=3 lane
    do_op(1, 8'h80, 8'h80, lat, sm, bm);
    chk("l3_latency", 32'(lat), 32'd20);
    chk("l3_sync_trace", sm, 32'h0000_0001);
    chk("l3_out_p", 32'(out_p[1]), 32'h0000_4000);
    drain(1, 1, 16'h4000, 8'h80);
    do_op(1, 8'h00, 8'hAA, lat, sm, bm);
    chk("l3_zero_p", 32'(out_p[1]), 32'h0000_0000);
    drain(1, 0, 16'h0000, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
